cpu_register_file: RTL
======================

Name: cpu_register_file

Overview:
- Holds the 6502 programmer-visible registers: A, X, Y, SP and status P.
- Its registered outputs drive the a_reg, x_reg, y_reg and sp inputs of the ALU input multiplexer.
- P goes to the branch and flag logic.
- Written from the ALU result bus by a destination code from the control unit; separately supports SP push/pull stepping and masked flag updates.

Parameters:
- SP_RESET, 8'hFD, SP value loaded on reset.
- P_RESET, 8'h24, P value loaded on reset (I=1, bit5=1).
- AUTO_NZ, 1, when 1 every A/X/Y write also updates N and Z from the written value.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  register write strobe
- dest_code  input  3  write target: 0 none, 1 A, 2 X, 3 Y, 4 SP, 5 P; 6/7 ignored
- wr_data  input  8  write data (ALU result or data bus)
- sp_op  input  2  stack step: 00 hold, 01 increment, 10 decrement, 11 hold
- flag_wr  input  1  masked flag update strobe
- flag_mask  input  8  P bits to update when flag_wr=1
- flag_in  input  8  new flag values, bit-aligned with P
- a_reg  output  8  accumulator
- x_reg  output  8  X index
- y_reg  output  8  Y index
- sp  output  8  stack pointer (page 1 offset)
- p_reg  output  8  status NV1BDIZC

Behaviour:
- Clock, reset and timing
  - One clock, clk.
  - Reset is asynchronous and active-low (rst_n).
  - While rst_n=0: a_reg=x_reg=y_reg=8'h00, sp=SP_RESET, p_reg=P_RESET; all inputs ignored.
  - Reset deassertion takes effect on the next clk edge; any operation in flight is lost.
  - All outputs come directly from flops. Zero combinational paths from inputs to outputs.
  - Updates are visible one cycle after the edge that samples them: write at edge N, new value on outputs after edge N.
- A/X/Y write
  - wr_en=1 with dest_code 1/2/3 loads wr_data into the selected register.
  - If AUTO_NZ=1: P[7] <= wr_data[7] and P[1] <= (wr_data==0) on the same edge.
- SP
  - wr_en=1 with dest_code=4 loads wr_data into sp (TXS); N/Z are not touched.
  - sp_op=01 gives sp <= sp+1; sp_op=10 gives sp <= sp-1.
  - 8-bit modulo wrap: FF+1=00, 00-1=FF. No overflow indication.
  - An explicit SP write has priority over sp_op in the same cycle; the step is discarded.
  - An A/X/Y/P write and an sp_op step in the same cycle both take effect (PLA/PLP pull pattern).
- P full write (PLP/RTI)
  - wr_en=1 with dest_code=5 loads wr_data into P, except P[5] forced 1 and P[4] forced 0.
  - flag_wr in the same cycle is ignored; the full write wins.
- Masked flag update
  - flag_wr=1 gives P[i] <= flag_in[i] for each i with flag_mask[i]=1.
  - Masked bits 5 and 4 are ignored: P[5] stays 1, P[4] stays 0 after any non-reset update.
- Flag priority (same cycle, per bit)
  - flag_wr wins over AUTO_NZ for masked bits.
  - AUTO_NZ applies to unmasked N/Z bits.
- Unused and idle inputs
  - wr_en=1 with dest_code 0/6/7 changes nothing.
  - wr_en=0 means dest_code and wr_data are don't-care.
- Invariant: P[5]=1 at all times, including reset, provided P_RESET[5]=1.
- Size target: 120-250 lines RTL.

Test Plan:
1. Reset: rst_n=0 mid-cycle after arbitrary writes -> immediately a/x/y=00, sp=FD, p=24, with no clock edge needed; release, idle 3 cycles -> values unchanged.
2. A/X/Y writes, AUTO_NZ=1:
   - A<=80 -> a_reg=80, P[7]=1, P[1]=0
   - X<=00 -> x_reg=00, P[7]=0, P[1]=1
   - Y<=05 -> y_reg=05, N=Z=0
   - dest_code=6 with data 55 -> no register changes
3. SP wrap: load sp=00 via dest 4, then sp_op=10 -> sp=FF; sp_op=01 -> sp=00; dest 4 data 40 with sp_op=01 in the same cycle -> sp=40.
4. Pull pattern: sp=FC; wr_en, dest 1, data 00, sp_op=01 in one cycle -> a_reg=00, sp=FD, Z=1.
5. P paths:
   - dest 5 data FF -> p_reg=EF
   - then flag_wr mask=01 in=00 -> p_reg=EE
   - flag_wr mask=30 in=00 -> p_reg unchanged EE
   - dest 5 with simultaneous flag_wr mask=FF in=00 -> P from wr_data only
6. Flag priority: A<=00 with flag_wr mask=02 in=00 in the same cycle -> Z=0 (flag_wr wins), N=0 from AUTO_NZ.

Source files
------------

// File: rtl/cpu_register_file_if.sv
// Register-file bus: write/step/flag controls from the control unit and the
// registered 6502 programmer-visible state returned to the datapath.
interface cpu_register_file_if;
    logic       wr_en;
    logic [2:0] dest_code;
    logic [7:0] wr_data;
    logic [1:0] sp_op;
    logic       flag_wr;
    logic [7:0] flag_mask;
    logic [7:0] flag_in;
    logic [7:0] a_reg;
    logic [7:0] x_reg;
    logic [7:0] y_reg;
    logic [7:0] sp;
    logic [7:0] p_reg;

    // Control unit side: drives the update controls, observes the registers.
    modport master (
        output wr_en, dest_code, wr_data, sp_op, flag_wr, flag_mask, flag_in,
        input  a_reg, x_reg, y_reg, sp, p_reg
    );

    // Register file side.
    modport slave (
        input  wr_en, dest_code, wr_data, sp_op, flag_wr, flag_mask, flag_in,
        output a_reg, x_reg, y_reg, sp, p_reg
    );
endinterface

// File: rtl/cpu_register_file.sv
// 6502 programmer-visible registers A, X, Y, SP and status P (NV1BDIZC).
// Written from the result bus by destination code, with independent SP
// push/pull stepping and masked flag updates. All outputs are flop outputs.
module cpu_register_file #(
    parameter logic [7:0] SP_RESET = 8'hFD,
    parameter logic [7:0] P_RESET  = 8'h24,
    parameter bit         AUTO_NZ  = 1'b1
) (
    input logic clk,
    input logic rst_n,
    cpu_register_file_if.slave bus
);

    typedef enum logic [2:0] {
        DEST_NONE = 3'd0,
        DEST_A    = 3'd1,
        DEST_X    = 3'd2,
        DEST_Y    = 3'd3,
        DEST_SP   = 3'd4,
        DEST_P    = 3'd5
    } dest_e;

    typedef enum logic [1:0] {
        SP_HOLD  = 2'b00,
        SP_INC   = 2'b01,
        SP_DEC   = 2'b10,
        SP_HOLD2 = 2'b11
    } sp_op_e;

    // Bit 5 of P is hard-wired high and the B bit (4) has no storage meaning
    // in P itself, so masked updates never reach them.
    localparam logic [7:0] FLAG_WR_MASK = 8'hCF;

    logic [7:0] a_q, x_q, y_q, sp_q, p_q;
    logic [7:0] a_d, x_d, y_d, sp_d, p_d;

    logic       wr_a, wr_x, wr_y, wr_sp, wr_p;
    logic [7:0] eff_mask;

    // Decode the write strobe into one-hot register enables.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wr_a  = 1'b0;
        wr_x  = 1'b0;
        wr_y  = 1'b0;
        wr_sp = 1'b0;
        wr_p  = 1'b0;
        if (bus.wr_en) begin
            case (bus.dest_code)
                DEST_A:  wr_a  = 1'b1;
                DEST_X:  wr_x  = 1'b1;
                DEST_Y:  wr_y  = 1'b1;
                DEST_SP: wr_sp = 1'b1;
                DEST_P:  wr_p  = 1'b1;
                default: ;  // DEST_NONE and codes 6/7 write nothing
            endcase
        end
    end

    // Next-state for A/X/Y and the stack pointer (explicit load beats a step).
    always_comb begin
        a_d  = wr_a ? bus.wr_data : a_q;
        x_d  = wr_x ? bus.wr_data : x_q;
        y_d  = wr_y ? bus.wr_data : y_q;
        sp_d = sp_q;
        if (wr_sp) begin
            sp_d = bus.wr_data;
        end else begin
            case (bus.sp_op)
                SP_INC:  sp_d = sp_q + 8'd1;  // wraps FF -> 00
                SP_DEC:  sp_d = sp_q - 8'd1;  // wraps 00 -> FF
                default: sp_d = sp_q;
            endcase
        end
    end

    // Next-state for P: full write wins outright; otherwise AUTO_NZ first,
    // then masked flag bits override it bit by bit.
    always_comb begin
        eff_mask = bus.flag_mask & FLAG_WR_MASK;
        p_d      = p_q;
        if (wr_p) begin
            p_d    = bus.wr_data;
            p_d[5] = 1'b1;
            p_d[4] = 1'b0;
        end else begin
            if (AUTO_NZ && (wr_a || wr_x || wr_y)) begin
                p_d[7] = bus.wr_data[7];
                p_d[1] = (bus.wr_data == 8'h00);
            end
            if (bus.flag_wr) begin
                p_d = (p_d & ~eff_mask) | (bus.flag_in & eff_mask);
            end
        end
    end

    // Register state; reset asynchronously to architectural power-up values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= 8'h00;
            x_q  <= 8'h00;
            y_q  <= 8'h00;
            sp_q <= SP_RESET;
            p_q  <= P_RESET;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            a_q  <= a_d;
            x_q  <= x_d;
            y_q  <= y_d;
            sp_q <= sp_d;
            p_q  <= p_d;
        end
    end

    assign bus.a_reg = a_q;
    assign bus.x_reg = x_q;
    assign bus.y_reg = y_q;
    assign bus.sp    = sp_q;
    assign bus.p_reg = p_q;

endmodule
